// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types, defaults and flag helper for the SAR search controller
package sar_pkg;

  localparam int SAR_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRY    = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Exactly one of the three comparator flags asserted.
  function automatic logic flags_onehot(input logic gt, input logic lt, input logic eq);
    return (gt ^ lt ^ eq) & ~(gt & lt & eq);
  endfunction

endpackage

// File: rtl/sar_four_if.sv
// rtl/sar_four_if.sv - control and comparator signals of the SAR search controller
interface sar_four_if
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
);

  logic             start;
  logic             greater_than;
  logic             less_than;
  logic             equal_to;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    input  start, greater_than, less_than, equal_to,
    output guess, busy, done, result, found, err
  );

  modport slave (
    output start, greater_than, less_than, equal_to,
    input  guess, busy, done, result, found, err
  );

endinterface

// File: rtl/sar_step.sv
// rtl/sar_step.sv - next trial operand and bit index for one successive-approximation step
module sar_step #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] guess_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             gt_i,
  output logic [WIDTH-1:0] guess_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  always_comb begin
    guess_o = guess_i;
    last_o  = (idx_i == '0);
    idx_o   = idx_i;
    if (gt_i) begin
      guess_o[idx_i] = 1'b0;
    end
    if (!last_o) begin
      guess_o[idx_i - IDX_W'(1)] = 1'b1;
      idx_o                      = idx_i - IDX_W'(1);
    end
  end

endmodule

// File: rtl/sar_four.sv
// rtl/sar_four.sv - MSB-first successive-approximation search against an external comparator
module sar_four
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  sar_four_if.master bus
);

  localparam int             IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_guess;
  logic [IDX_W-1:0] step_idx;
  logic             step_last;
  logic             onehot;

  sar_step #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_step (
    .guess_i (guess_q),
    .idx_i   (idx_q),
    .gt_i    (bus.greater_than),
    .guess_o (step_guess),
    .idx_o   (step_idx),
    .last_o  (step_last)
  );

  assign onehot = flags_onehot(bus.greater_than, bus.less_than, bus.equal_to);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      idx_q    <= IDX_TOP;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        guess_d = '0;
        if (bus.start) begin
          guess_d = MSB_ONLY;
          idx_d   = IDX_TOP;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = TRY;
        end
      end
      TRY: begin
        if (!onehot) begin
          result_d = guess_q;
          err_d    = 1'b1;
          found_d  = 1'b0;
          state_d  = DONE;
        end else if (bus.equal_to) begin
          result_d = guess_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else begin
          guess_d = step_guess;
          idx_d   = step_idx;
          if (step_last) begin
            state_d = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (!onehot) begin
          err_d = 1'b1;
        end else begin
          found_d = bus.equal_to;
        end
        result_d = guess_q;
        state_d  = DONE;
      end
      DONE: begin
        // Return the comparator operand to zero so IDLE always presents 0.
        guess_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = (state_q == TRY) || (state_q == VERIFY);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;

endmodule
